// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth-table checker: function codes, FSM states and the
// reference gate function.
package gate_chk_pkg;

    localparam logic [2:0] FUNC_AND  = 3'd0;
    localparam logic [2:0] FUNC_OR   = 3'd1;
    localparam logic [2:0] FUNC_NAND = 3'd2;
    localparam logic [2:0] FUNC_NOR  = 3'd3;
    localparam logic [2:0] FUNC_XOR  = 3'd4;
    localparam logic [2:0] FUNC_XNOR = 3'd5;

    localparam int unsigned MAX_IN = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } state_e;

    function automatic logic func_legal(input logic [2:0] func);
        return func <= FUNC_XNOR;
    endfunction

    // vec is zero-extended to MAX_IN; bits above n_in are masked out of every reduction.
    function automatic logic expected_out(input logic [2:0] func, input logic [MAX_IN-1:0] vec,
                                          input int unsigned n_in);
        logic [MAX_IN-1:0] w_mask;
        logic              w_and;
        logic              w_or;
        logic              w_xor;
        w_mask = MAX_IN'((1 << n_in) - 1);
        w_and  = &(vec | ~w_mask);
        w_or   = |(vec & w_mask);
        w_xor  = ^(vec & w_mask);
        case (func)
            FUNC_AND:  return w_and;
            FUNC_OR:   return w_or;
            FUNC_NAND: return ~w_and;
            FUNC_NOR:  return ~w_or;
            FUNC_XOR:  return w_xor;
            FUNC_XNOR: return ~w_xor;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gate_tt_checker_if.sv
// Control, stimulus and result bundle between the checker and whoever drives it.
interface gate_tt_checker_if #(
    parameter int unsigned N_IN = 2
);
    logic                   start;
    logic [2:0]             func;
    logic                   dut_y;
    logic [N_IN-1:0]        vec;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          err_count;
    logic [(1 << N_IN)-1:0] fail_map;

    modport master (
        output start, func, dut_y,
        input  vec, busy, done, pass, err_count, fail_map
    );

    modport slave (
        input  start, func, dut_y,
        output vec, busy, done, pass, err_count, fail_map
    );
endinterface

// File: rtl/settle_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
module settle_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/gate_tt_checker.sv
// Truth-table checker: walks all input vectors onto a 2-input gate, samples its output after a
// settle interval and accumulates a fail map, an error count and a pass flag.
module gate_tt_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned N_IN          = 2,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic         i_clk,
    input logic         i_rst,
    gate_tt_checker_if.slave bus
);
    localparam int unsigned NVEC  = 1 << N_IN;
    localparam int unsigned CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    // Counter holds the settle cycles still to go after the current one.
    localparam logic [CNT_W-1:0] RELOAD = (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  LAST_VEC     = N_IN'(NVEC - 1);
    localparam logic [N_IN:0]    ALL_FAIL_CNT = (N_IN + 1)'(NVEC);
    localparam state_e           FIRST_ST     = (SETTLE_CYCLES == 0) ? StSample : StSettle;

    state_e            r_state, w_state_next;
    logic [2:0]        r_func, w_func_next;
    logic [N_IN-1:0]   r_vec, w_vec_next;
    logic [N_IN:0]     r_err, w_err_next;
    logic [NVEC-1:0]   r_fail, w_fail_next;
    logic              r_pass, w_pass_next;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_zero;
    logic              w_exp;
    logic              w_mismatch;

    settle_counter #(
        .WIDTH (CNT_W)
    ) u_settle_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_cnt_load),
        .i_load_val (RELOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    assign w_exp      = expected_out(r_func, MAX_IN'(r_vec), N_IN);
    // Case inequality so an undriven or unknown gate output counts as a failure.
    assign w_mismatch = (bus.dut_y !== w_exp);

    always_comb begin
        w_state_next = r_state;
        w_func_next  = r_func;
        w_vec_next   = r_vec;
        w_err_next   = r_err;
        w_fail_next  = r_fail;
        w_pass_next  = r_pass;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_func_next = bus.func;
                    w_vec_next  = '0;
                    w_err_next  = '0;
                    w_fail_next = '0;
                    w_pass_next = 1'b0;
                    w_cnt_load  = 1'b1;
                    if (!func_legal(bus.func)) begin
                        w_err_next   = ALL_FAIL_CNT;
                        w_fail_next  = '1;
                        w_state_next = StDone;
                    end else begin
                        w_state_next = FIRST_ST;
                    end
                end
            end
            StSettle: begin
                if (w_cnt_zero) begin
                    w_state_next = StSample;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            StSample: begin
                if (w_mismatch) begin
                    w_fail_next[r_vec] = 1'b1;
                    w_err_next         = r_err + 1'b1;
                end
                if (r_vec == LAST_VEC) begin
                    w_state_next = StDone;
                    w_pass_next  = (w_err_next == '0);
                end else begin
                    w_vec_next   = r_vec + 1'b1;
                    w_cnt_load   = 1'b1;
                    w_state_next = FIRST_ST;
                end
            end
            StDone: begin
                w_pass_next  = (r_err == '0);
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_func  <= FUNC_AND;
            r_vec   <= '0;
            r_err   <= '0;
            r_fail  <= '0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_func  <= w_func_next;
            r_vec   <= w_vec_next;
            r_err   <= w_err_next;
            r_fail  <= w_fail_next;
            r_pass  <= w_pass_next;
        end
    end

    assign bus.vec       = r_vec;
    assign bus.busy      = (r_state == StSettle) || (r_state == StSample);
    assign bus.done      = (r_state == StDone);
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;
    assign bus.fail_map  = r_fail;
endmodule

// File: doc/gate_tt_checker.md
# gate_tt_checker

Sequential truth-table checker for the 2-input switch-level gate cells in this module set (AND, OR, NAND, NOR, XOR, XNOR). It sits on both sides of the gate under test. Upstream, it drives every input combination onto the gate. Downstream, it samples the gate output after a programmable settle interval and compares it with the expected function. It reports a per-vector fail map, an error count and a pass flag.

## Interface
- `N_IN`, default 2: number of gate inputs. Vector count is 2^N_IN.
- `SETTLE_CYCLES`, default 2: cycles each vector is held before the sample cycle. 0 is legal.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin a run; accepted only in IDLE.
- `func`  in  3  expected function, latched on the accepted start.
  - 0=AND, 1=OR, 2=NAND, 3=NOR, 4=XOR, 5=XNOR, 6/7 illegal.
- `dut_y`  in  1  output of the gate under test.
- `vec`  out  N_IN  registered input vector to the gate; bit 0 → input a, bit 1 → input b.
- `busy`  out  1  high in SETTLE and SAMPLE.
- `done`  out  1  one-cycle pulse in the DONE state.
- `pass`  out  1  1 when the last run had zero errors; held until the next accepted start.
- `err_count`  out  N_IN+1  number of failing vectors in the last run.
- `fail_map`  out  2^N_IN  bit k set when vector k failed.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE & start:
  - latch func; vec←0; settle counter←SETTLE_CYCLES.
  - clear err_count, fail_map and pass.
  - next state is SETTLE, or SAMPLE if SETTLE_CYCLES=0.
- SETTLE: counter decrements each cycle and vec is held. When counter reaches 1, next state is SAMPLE.
- SAMPLE: compare dut_y with expected(vec).
  - Mismatch: fail_map[vec]←1 and err_count←err_count+1.
  - If vec is not the last vector: vec←vec+1, reload the counter, return to SETTLE (or stay in SAMPLE when SETTLE_CYCLES=0).
  - If vec = 2^N_IN−1: go to DONE and leave vec unchanged. vec never wraps within a run.
- Expected function is the reduction of vec: AND=&vec, OR=|vec, NAND=~&vec, NOR=~|vec, XOR=^vec, XNOR=~^vec.
- Illegal func (6/7) on start:
  - skip vector application and go straight to DONE;
  - err_count←2^N_IN, fail_map←all ones, pass=0.
- DONE: done=1 and pass←(err_count==0), both for one cycle. Next state is IDLE.
- start is ignored outside IDLE, including in the DONE cycle. func changes after latching have no effect.
- dut_y is treated as a 2-state value; a z/x sample counts as a mismatch.
- rst at any edge, including mid-run: state←IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, fail_map=0.

## Timing
- Start is accepted at edge E0.
- Vector k occupies SETTLE_CYCLES+1 cycles and is sampled at the end of cycle E0+1+k·(SETTLE_CYCLES+1)+SETTLE_CYCLES.
- done is high during cycle E0+1+2^N_IN·(SETTLE_CYCLES+1). With defaults, that is the 13th cycle after E0.
- Illegal func: done is high in the cycle after E0.
- All outputs are registered, with no combinational path from inputs to outputs.
- A new start is accepted at the earliest one cycle after done.

## Structure
- Shared package `gate_chk_pkg` holds:
  - func code localparams (FUNC_AND…FUNC_XNOR);
  - the state encoding;
  - an `expected_out(func, vec)` function.
- Optional sub-module `settle_counter`: loadable down-counter with a zero flag.
- The top module is the FSM plus the result registers.

## Test plan
- `and_primitive` as the gate, func=0, defaults → vec steps 0,1,2,3; done at cycle 13; pass=1; err_count=0; fail_map=4'b0000.
- Gate modelled as OR with func=0 → vectors 1 and 2 fail; err_count=2; fail_map=4'b0110; pass=0.
- func=6 → done the cycle after start; err_count=4; fail_map=4'b1111; pass=0.
- SETTLE_CYCLES=0 with a matching gate → one vector per cycle; done 5 cycles after start; pass=1.
- rst asserted while vec=2 in SETTLE → next edge gives all outputs 0 and state IDLE. A new start then runs to completion with correct results.
- start pulsed while busy and during the done cycle → ignored; vec sequence and results unchanged; no extra done pulse.
